// File: rtl/shifter_pipe.sv
// shifter_pipe: two-stage LSL/LSR/ASR/ROR/RRX shifter with valid/ready flow control and flush
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  input  logic             in_cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout
);
  localparam int LG = $clog2(WIDTH);
  logic               s1_v, s1_c, s2_v, s2_c, s2_adv, z, cout;
  logic [WIDTH-1:0]   s1_d, s2_d, ror, res;
  logic [AMT_W-1:0]   s1_a;
  logic [2:0]         s1_m;
  logic [LG-1:0]      r;
  logic [WIDTH:0]     lsl, lsr;
  logic signed [WIDTH:0] asr;
  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v;
  assign out_data  = s2_d;
  assign out_cout  = s2_c;
  // the extra bit on each shift carries the last bit shifted out, i.e. the carry
  always_comb begin
    r    = s1_a[LG-1:0];
    z    = s1_a == '0;
    lsl  = {1'b0, s1_d} << s1_a;
    lsr  = {s1_d, 1'b0} >> s1_a;
    asr  = $signed({s1_d, 1'b0}) >>> s1_a;
    ror  = (s1_d >> r) | (s1_d << (WIDTH - int'(r)));
    res  = s1_m == 3'd4 ? {s1_c, s1_d[WIDTH-1:1]} :
           (s1_m > 3'd4 || z) ? s1_d :
           s1_m == 3'd0 ? lsl[WIDTH-1:0] :
           s1_m == 3'd1 ? lsr[WIDTH:1] :
           s1_m == 3'd2 ? asr[WIDTH:1] : ror;
    cout = s1_m == 3'd4 ? s1_d[0] :
           (s1_m > 3'd4 || z) ? s1_c :
           s1_m == 3'd0 ? lsl[WIDTH] :
           s1_m == 3'd1 ? lsr[0] :
           s1_m == 3'd2 ? asr[0] : ror[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2_d <= '0;
      s2_c <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_d <= res;
          s2_c <= cout;
        end
      end
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_d <= in_data;
          s1_a <= in_amt;
          s1_m <= in_mode;
          s1_c <= in_cin;
        end
      end
    end
  end
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: randomized bench against a queue-based reference of the shifter pipeline
module tb_shifter_pipe;
  localparam int W = 32, AW = 8;
  logic clk = 0, rst = 1, in_valid = 0, in_cin = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid, out_cout;
  logic [W-1:0] in_data = '0, out_data;
  logic [AW-1:0] in_amt = '0;
  logic [2:0] in_mode = '0;
  int checks = 0, errors = 0;
  logic [32:0] q_res[$];
  int q_age[$];
  logic [2:0] dm[8] = '{3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
  logic [31:0] dd[8] = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
                         32'h80000001, 32'h80000000, 32'h80000000, 32'h00000001};
  int da[8] = '{1, 32, 0, 32, 33, 32, 40, 5};
  logic dc[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_v, exp_rdy, zr = 0;
  always #5 clk = ~clk;
  shifter_pipe #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode), .in_cin(in_cin), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cout(out_cout)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] ref_shift(input logic [2:0] m, input logic [31:0] d, input int a, input logic c);
    logic [63:0] x;
    logic [31:0] o;
    int r;
    if (m > 3'd4) return {c, d};
    if (m == 3'd4) return {d[0], c, d[31:1]};
    if (a == 0) return {c, d};
    if (m == 3'd0) begin
      if (a > 32) return '0;
      x = {32'b0, d} << a;
      return {d[32-a], x[31:0]};
    end
    if (m == 3'd1) begin
      if (a > 32) return '0;
      x = {32'b0, d} >> a;
      return {d[a-1], x[31:0]};
    end
    if (m == 3'd2) begin
      if (a >= 32) return {33{d[31]}};
      x = {{32{d[31]}}, d} >> a;
      return {d[a-1], x[31:0]};
    end
    r = a % 32;
    if (r == 0) return {d[31], d};
    o = (d >> r) | (d << (32 - r));
    return {o[31], o};
  endfunction
  initial begin
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_v = q_res.size() > 0 && q_age[0] >= 2;
      if (!rst) begin
        chk("out_valid", {63'b0, out_valid}, {63'b0, exp_v});
        if (exp_v) begin
          chk("out_data", {32'b0, out_data}, {32'b0, q_res[0][31:0]});
          chk("out_cout", {63'b0, out_cout}, {63'b0, q_res[0][32]});
          zr = 0;
        end else if (zr) begin
          chk("rst_data", {32'b0, out_data}, 64'b0);
          chk("rst_cout", {63'b0, out_cout}, 64'b0);
        end
      end
      rst = cyc < 2 || cyc == 26 || (cyc > 40 && $urandom_range(0, 199) == 0);
      flush = cyc == 20 || (cyc > 40 && $urandom_range(0, 49) == 0);
      in_data = $urandom;
      in_amt = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 40));
      in_mode = 3'($urandom_range(0, 7));
      in_cin = 1'($urandom);
      if (cyc >= 2 && cyc < 10) begin
        in_valid = 1;
        out_ready = 1;
        in_mode = dm[cyc-2];
        in_data = dd[cyc-2];
        in_amt = AW'(da[cyc-2]);
        in_cin = dc[cyc-2];
      end else if (cyc < 17) begin
        in_valid = cyc < 13;
        out_ready = cyc >= 14;
      end else if (cyc < 26) begin
        in_valid = 1;
        out_ready = cyc > 20;
      end else begin
        in_valid = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 2) != 0;
      end
      #1;
      exp_rdy = q_res.size() < 2 || out_ready;
      if (!rst) chk("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
      if (rst || flush) begin
        q_res.delete();
        q_age.delete();
        if (rst) zr = 1;
      end else begin
        if (exp_v && out_ready) begin
          void'(q_res.pop_front());
          void'(q_age.pop_front());
        end
        foreach (q_age[i]) q_age[i]++;
        if (in_valid && exp_rdy) begin
          q_res.push_back(ref_shift(in_mode, in_data, int'(in_amt), in_cin));
          q_age.push_back(1);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; legal values are powers of two, 8 or more.
REQ-002 SHALL have parameter AMT_W, default 8: shift-amount width; legal values satisfy AMT_W >= log2(WIDTH)+1.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the offered operation this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: operand.
REQ-008 SHALL have port in_amt, input, AMT_W: unsigned shift amount.
REQ-009 SHALL have port in_mode, input, 3: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101-111 reserved.
REQ-010 SHALL have port in_cin, input, 1: incoming carry flag.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all in-flight operations.
REQ-012 SHALL have port out_valid, output, 1: a result is presented.
REQ-013 SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-014 SHALL have port out_data, output, WIDTH: shifted result.
REQ-015 SHALL have port out_cout, output, 1: shifter carry-out.

Function (N = WIDTH, a = in_amt)
REQ-016 LSL SHALL behave as follows.
- a=0: out=in, cout=cin.
- 1<=a<=N: out=in<<a, cout=in[N-a].
- a>N: out=0, cout=0.
REQ-017 LSR SHALL behave as follows.
- a=0: out=in, cout=cin.
- 1<=a<=N: out=in>>a (zero fill), cout=in[a-1].
- a>N: out=0, cout=0.
REQ-018 ASR SHALL behave as follows.
- a=0: out=in, cout=cin.
- 1<=a<N: arithmetic shift right by a, cout=in[a-1].
- a>=N: every bit equals in[N-1], cout=in[N-1].
REQ-019 ROR SHALL behave as follows.
- a=0: out=in, cout=cin.
- a!=0 and a mod N = 0: out=in, cout=in[N-1].
- otherwise: rotate right by (a mod N), cout=out[N-1].
REQ-020 RRX SHALL produce out={cin, in[N-1:1]} and cout=in[0]; in_amt is ignored.
REQ-021 Reserved modes SHALL produce out=in and cout=cin.
REQ-022 The datapath SHALL be two register stages (S1, S2); S2 drives out_valid, out_data and out_cout directly from flops.
REQ-023 An operation is accepted when in_valid&&in_ready; with out_ready held high, out_valid for it SHALL assert exactly 2 cycles after acceptance.
REQ-024 Throughput SHALL be one operation per cycle while out_ready is high.
REQ-025 in_ready SHALL equal !S1_valid || !S2_valid || out_ready (a stage advances when its successor is empty or draining).
REQ-026 While out_valid && !out_ready, out_data and out_cout SHALL hold stable and S2 SHALL not change.
REQ-027 With out_ready low, at most two operations SHALL be buffered; in_ready SHALL then be 0.
REQ-028 Results SHALL leave in acceptance order; no operation SHALL be dropped or duplicated.
REQ-029 Input values SHALL be sampled only on the cycle of acceptance; later changes on the input ports SHALL not affect accepted operations.
REQ-030 flush=1 SHALL clear S1_valid and S2_valid at the next edge; any acceptance in that same cycle SHALL also be discarded; out_data is don't-care while out_valid=0.
REQ-031 Simultaneous S2 drain and S1->S2 advance and new acceptance SHALL all complete in one cycle.

Reset
REQ-032 While rst=1 at an edge, S1_valid, S2_valid, out_valid, out_data and out_cout SHALL become 0.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 rst SHALL take priority over flush and over any handshake; in-flight operations at reset are lost.

Verification (WIDTH=32, AMT_W=8)
REQ-035 ROR 0x80000001, a=1 -> 0xC0000000, cout=1; a=32 -> 0x80000001, cout=1; a=0, cin=0 -> 0x80000001, cout=0.
REQ-036 LSL 0x80000001: a=32 -> 0, cout=1; a=33 -> 0, cout=0. LSR 0x80000000: a=32 -> 0, cout=1.
REQ-037 ASR 0x80000000, a=40 -> 0xFFFFFFFF, cout=1. RRX 0x00000001, cin=1 -> 0x80000000, cout=1.
REQ-038 Three back-to-back ops with out_ready=0 for 4 cycles -> in_ready=0 after two accepted, third held; on release the three results appear in order, one per cycle.
REQ-039 rst pulsed while two ops are in flight -> out_valid=0, out_data=0, out_cout=0 next cycle; in_ready=1; no stale result ever appears.
REQ-040 flush asserted with one op in S2 under stall and a new op offered -> both discarded; out_valid=0 next cycle.
